// File: rtl/dac_sample_scheduler_if.sv
// Purpose: request/response and load-strobe bundle between the sample scheduler and the DAC buffer/drivers.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; the buffer answers each request exactly one cycle later.
interface dac_sample_scheduler_if;
   logic dac_request;
   logic dac_buffer_ready;
   logic dac_underrun;
   logic src_load;
   logic bist_load;

   // Scheduler side: issues requests and load strobes, consumes the buffer response.
   modport master (
      output dac_request,
      output src_load,
      output bist_load,
      input  dac_buffer_ready,
      input  dac_underrun
   );

   // Buffer/driver side: answers requests, receives load strobes.
   modport slave (
      input  dac_request,
      input  src_load,
      input  bist_load,
      output dac_buffer_ready,
      output dac_underrun
   );
endinterface

// File: rtl/dac_sample_scheduler.sv
// Purpose: paces DAC sample requests at DIVIDER cycles and routes each valid sample to the source or BIST DAC.
// Latency: load strobe exactly 1 cycle after its request; the first request after open primes the buffer and is discarded.
// Backpressure: none; a missing or underrun response drops that sample. Optional DAC_SCHED_STATS_EN builds the counters.
//
// DIVIDER must be at least CHANNELS+3 so the priming blackout ends before the first tick.
// dac_open low (or reset) clears all state, and every output is forced to 0 combinationally in that cycle too.
module dac_sample_scheduler #(
   parameter int DIVIDER  = 256,
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
) (
   input  logic                   capture_clk,
   input  logic                   reset,
   input  logic                   dac_open,
   input  logic [1:0]             mode,
   dac_sample_scheduler_if.master dac_bus,
   output logic                   acq_start,
   output logic                   mode_error,
   output logic [CNT_W-1:0]       sample_count,
   output logic [CNT_W-1:0]       underrun_count
);

   localparam int TICK_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(DIVIDER - 1);

   localparam int PH_W = $clog2(CHANNELS + 1) + 1;
   // P_WAIT spans CHANNELS+1 cycles: phase counts CHANNELS down to 0.
   localparam logic [PH_W-1:0] PH_PRIME = PH_W'(CHANNELS);
   // BLANK spans CHANNELS-1 cycles: phase counts CHANNELS-2 down to 0.
   localparam logic [PH_W-1:0] PH_BLANK = PH_W'((CHANNELS > 1) ? (CHANNELS - 2) : 0);

   localparam logic [1:0] MODE_SRC  = 2'b01;
   localparam logic [1:0] MODE_BIST = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      P_WAIT,
      WAIT_TICK,
      RESP,
      BLANK
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              active;
   logic              clr;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic              tick_pend;
   logic              serve;
   logic [PH_W-1:0]   phase;
   logic [1:0]        run_mode;
   logic              acq_q;
   logic              mode_error_q;
   logic              req_c;
   logic              load_c;
   logic              miss_c;

   assign active = dac_open && !reset;
   assign clr    = !active;

   // Tick fires when the free-running period counter hits zero, outside IDLE only.
   assign tick  = (state != IDLE) && (tick_cnt == '0);
   // A tick seen in WAIT_TICK, or one remembered from an earlier state, releases the next request.
   assign serve = tick || tick_pend;

   // FSM state register.
   always_ff @(posedge capture_clk) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (mode == MODE_SRC || mode == MODE_BIST) begin
               state_nxt = PRIME;
            end
         end
         PRIME:     state_nxt = P_WAIT;
         P_WAIT: begin
            if (phase == '0) begin
               state_nxt = WAIT_TICK;
            end
         end
         WAIT_TICK: begin
            if (serve) begin
               state_nxt = RESP;
            end
         end
         RESP:      state_nxt = (CHANNELS > 1) ? BLANK : WAIT_TICK;
         BLANK: begin
            if (phase == '0) begin
               state_nxt = WAIT_TICK;
            end
         end
         default:   state_nxt = IDLE;
      endcase
   end

   // FSM outputs: request, load qualification and underrun detection, all killed while closed.
   always_comb begin
      req_c  = 1'b0;
      load_c = 1'b0;
      miss_c = 1'b0;
      case (state)
         PRIME:     req_c = 1'b1;
         WAIT_TICK: req_c = serve;
         RESP: begin
            // Underrun beats ready; no response at all is treated as an underrun.
            if (dac_bus.dac_underrun || !dac_bus.dac_buffer_ready) begin
               miss_c = 1'b1;
            end else begin
               load_c = 1'b1;
            end
         end
         default: ;
      endcase
      if (!active) begin
         req_c  = 1'b0;
         load_c = 1'b0;
         miss_c = 1'b0;
      end
   end

   assign dac_bus.dac_request = req_c;
   assign dac_bus.src_load    = load_c && (run_mode == MODE_SRC);
   assign dac_bus.bist_load   = load_c && (run_mode == MODE_BIST);

   // Sample-period counter: held at DIVIDER-1 in IDLE, free-running and reloading otherwise.
   always_ff @(posedge capture_clk) begin
      if (clr || state == IDLE) begin
         tick_cnt <= TICK_RELOAD;
      end else if (tick_cnt == '0) begin
         tick_cnt <= TICK_RELOAD;
      end else begin
         tick_cnt <= tick_cnt - TICK_W'(1);
      end
   end

   // Remember a tick that lands outside WAIT_TICK so it is served once, never dropped.
   always_ff @(posedge capture_clk) begin
      if (clr || state == IDLE) begin
         tick_pend <= 1'b0;
      end else if (state == WAIT_TICK && serve) begin
         tick_pend <= 1'b0;
      end else if (tick) begin
         tick_pend <= 1'b1;
      end
   end

   // Blackout timer shared by P_WAIT and BLANK.
   always_ff @(posedge capture_clk) begin
      if (clr) begin
         phase <= '0;
      end else if (state == PRIME) begin
         phase <= PH_PRIME;
      end else if (state == RESP) begin
         phase <= PH_BLANK;
      end else if (phase != '0) begin
         phase <= phase - PH_W'(1);
      end
   end

   // Capture the routing mode once when the pipe starts; later mode changes do not reroute.
   always_ff @(posedge capture_clk) begin
      if (clr) begin
         run_mode <= 2'b00;
      end else if (state == IDLE && state_nxt == PRIME) begin
         run_mode <= mode;
      end
   end

   // Sticky mode error: reserved mode at open, or any mode change after the start.
   always_ff @(posedge capture_clk) begin
      if (clr) begin
         mode_error_q <= 1'b0;
      end else if ((state == IDLE && mode == MODE_RSVD) ||
                   (state != IDLE && mode != run_mode)) begin
         mode_error_q <= 1'b1;
      end
   end

   // Acquisition start latches on the first real load of this open period.
   always_ff @(posedge capture_clk) begin
      if (clr) begin
         acq_q <= 1'b0;
      end else if (load_c) begin
         acq_q <= 1'b1;
      end
   end

   // acq_start rises in the same cycle as the first load so capture aligns with output.
   assign acq_start  = active && (acq_q || load_c);
   assign mode_error = active && mode_error_q;

`ifdef DAC_SCHED_STATS_EN
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] underrun_cnt;

   // Saturating load and underrun counters, cleared whenever the pipe is closed.
   always_ff @(posedge capture_clk) begin
      if (clr) begin
         sample_cnt   <= '0;
         underrun_cnt <= '0;
      end else begin
         if (load_c && sample_cnt != '1) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
         end
         if (miss_c && underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + CNT_W'(1);
         end
      end
   end

   assign sample_count   = active ? sample_cnt   : '0;
   assign underrun_count = active ? underrun_cnt : '0;
`else
   assign sample_count   = '0;
   assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Purpose: self-checking bench for dac_sample_scheduler against a cycle-arithmetic reference model.
// Latency: model expects requests at open+1 and open+n*DIVIDER, loads one cycle after each real request.
// Backpressure: the bench plays the buffer, answering with ready/underrun patterns, some random.
module tb_dac_sample_scheduler;
   localparam int D = 16;
   localparam int C = 4;
   localparam int W = 4;
`ifdef DAC_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int P_READY = 0;
   localparam int P_RAND  = 1;
   localparam int P_UND34 = 2;
   localparam int P_BOTH  = 3;

   logic         capture_clk = 1'b0;
   logic         reset;
   logic         dac_open;
   logic [1:0]   mode;
   logic         acq_start;
   logic         mode_error;
   logic [W-1:0] sample_count;
   logic [W-1:0] underrun_count;

   dac_sample_scheduler_if bus ();

   dac_sample_scheduler #(
      .DIVIDER  (D),
      .CHANNELS (C),
      .CNT_W    (W)
   ) dut (
      .capture_clk    (capture_clk),
      .reset          (reset),
      .dac_open       (dac_open),
      .mode           (mode),
      .dac_bus        (bus.master),
      .acq_start      (acq_start),
      .mode_error     (mode_error),
      .sample_count   (sample_count),
      .underrun_count (underrun_count)
   );

   always #5 capture_clk = ~capture_clk;

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   bit         sess     = 1'b0;
   int         k        = 0;
   logic [1:0] rmode    = 2'b00;
   bit         acq_m    = 1'b0;
   bit         merr_m   = 1'b0;
   int         loads_m  = 0;
   int         unds_m   = 0;
   bit         found;
   int         len;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] sat(input int v);
      if (v >= (2 ** W) - 1) return '1;
      return W'(v);
   endfunction

   // Real sample number whose response is due in the current cycle, 0 if none.
   function automatic int resp_idx();
      int rel;
      if (!sess) return 0;
      rel = cyc - k;
      if (rel > D && ((rel - 1) % D) == 0) return (rel - 1) / D;
      return 0;
   endfunction

   task automatic drive_buf(input int pol);
      int n;
      case (pol)
         P_READY: begin
            bus.dac_buffer_ready = 1'b1;
            bus.dac_underrun     = 1'b0;
         end
         P_RAND: begin
            bus.dac_buffer_ready = ($urandom_range(0, 3) != 0);
            bus.dac_underrun     = ($urandom_range(0, 4) == 0);
         end
         P_UND34: begin
            n = resp_idx();
            bus.dac_buffer_ready = 1'b1;
            bus.dac_underrun     = (n == 3 || n == 4);
         end
         default: begin
            bus.dac_buffer_ready = 1'b1;
            bus.dac_underrun     = 1'b1;
         end
      endcase
   endtask

   // One clock cycle: predict, compare at the falling edge, update model, advance past the rising edge.
   task automatic step();
      bit           open_c;
      bit           exp_req;
      bit           exp_ld;
      bit           exp_miss;
      int           rel;
      logic [W-1:0] exp_sc;
      logic [W-1:0] exp_uc;
      open_c   = dac_open && !reset;
      exp_req  = 1'b0;
      exp_ld   = 1'b0;
      exp_miss = 1'b0;
      if (!open_c) begin
         sess    = 1'b0;
         acq_m   = 1'b0;
         merr_m  = 1'b0;
         loads_m = 0;
         unds_m  = 0;
      end else if (!sess && (mode == 2'b01 || mode == 2'b10)) begin
         sess  = 1'b1;
         k     = cyc;
         rmode = mode;
      end
      if (sess) begin
         rel     = cyc - k;
         exp_req = (rel == 1) || (rel >= D && (rel % D) == 0);
         if (resp_idx() > 0) begin
            if (bus.dac_buffer_ready && !bus.dac_underrun) exp_ld = 1'b1;
            else exp_miss = 1'b1;
         end
      end
      exp_sc = (open_c && STATS) ? sat(loads_m) : '0;
      exp_uc = (open_c && STATS) ? sat(unds_m)  : '0;
      @(negedge capture_clk);
      check("dac_request",    bus.dac_request, exp_req);
      check("src_load",       bus.src_load,    exp_ld && rmode == 2'b01);
      check("bist_load",      bus.bist_load,   exp_ld && rmode == 2'b10);
      check("acq_start",      acq_start,       open_c && (acq_m || exp_ld));
      check("mode_error",     mode_error,      open_c && merr_m);
      check("sample_count",   sample_count,    exp_sc);
      check("underrun_count", underrun_count,  exp_uc);
      if (open_c) begin
         if (exp_ld) begin
            acq_m = 1'b1;
            loads_m++;
         end
         if (exp_miss) unds_m++;
         if (!sess && mode == 2'b11) merr_m = 1'b1;
         if (sess && cyc > k && mode != rmode) merr_m = 1'b1;
      end
      @(posedge capture_clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n, input int pol);
      for (int i = 0; i < n; i++) begin
         drive_buf(pol);
         step();
      end
   endtask

   task automatic close(input int n);
      dac_open = 1'b0;
      run(n, P_RAND);
   endtask

   initial begin
      // Reset held with the pipe already open: everything must read 0.
      reset                = 1'b1;
      dac_open             = 1'b1;
      mode                 = 2'b01;
      bus.dac_buffer_ready = 1'b0;
      bus.dac_underrun     = 1'b0;
      run(3, P_READY);

      // Source DAC, buffer always ready, long enough to saturate the load counter.
      reset = 1'b0;
      run(20 * D, P_READY);
      check("t1_acq_start", acq_start, 1);
      check("t1_sample_sat", sample_count, STATS ? 15 : 0);
      close(3);

      // BIST DAC with underruns on samples 3 and 4.
      mode     = 2'b10;
      dac_open = 1'b1;
      run(7 * D, P_UND34);
      check("t2_underrun_count", underrun_count, STATS ? 2 : 0);
      check("t2_sample_count", sample_count, STATS ? 4 : 0);
      close(2);

      // Mode change while running, then clean reopen.
      mode     = 2'b01;
      dac_open = 1'b1;
      run(3 * D, P_RAND);
      mode = 2'b10;
      run(3 * D, P_READY);
      check("t3_mode_error", mode_error, 1);
      close(2);
      dac_open = 1'b1;
      run(3 * D, P_READY);
      check("t3_reopen_mode_error", mode_error, 0);
      close(2);

      // Close exactly in the response cycle of sample 2.
      mode     = 2'b01;
      dac_open = 1'b1;
      found    = 1'b0;
      for (int i = 0; i < 4 * D && !found; i++) begin
         drive_buf(P_READY);
         if (resp_idx() == 2) begin
            dac_open = 1'b0;
            found    = 1'b1;
         end
         step();
      end
      check("t4_resp_found", found, 1);
      check("t4_acq_cleared", acq_start, 0);
      run(1, P_READY);
      dac_open = 1'b1;
      run(2 * D, P_READY);
      close(2);

      // Reserved mode at open, then simultaneous ready and underrun.
      mode     = 2'b11;
      dac_open = 1'b1;
      run(40, P_RAND);
      check("t5_mode_error", mode_error, 1);
      close(2);
      mode     = 2'b01;
      dac_open = 1'b1;
      run(3 * D, P_BOTH);
      check("t5_both_underruns", underrun_count, STATS ? 2 : 0);
      check("t5_both_no_acq", acq_start, 0);
      close(2);

      // Random sessions with random responses and random close points.
      for (int s = 0; s < 6; s++) begin
         mode     = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
         dac_open = 1'b1;
         len      = $urandom_range(D, 6 * D);
         for (int i = 0; i < len; i++) begin
            if (s == 3 && i == len / 2) mode = ~mode;
            drive_buf(P_RAND);
            step();
         end
         close($urandom_range(1, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
